// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: write, lock, commit and read requests plus the
// registered read/status responses.
interface reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             lock_en;
  logic [AW-1:0]    lock_addr;
  logic             commit;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_err;
  logic             dirty;

  modport master (
    output wr_en, wr_addr, wr_data, lock_en, lock_addr, commit, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_err, dirty
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, lock_en, lock_addr, commit, rd_en, rd_addr,
    output rd_data, rd_valid, wr_err, dirty
  );
endinterface

// File: rtl/reg_bank.sv
// Addressed bank of DEPTH configuration registers with sticky per-register
// write locks, a registered read port and an optional shadow/commit stage
// that lets software publish several writes atomically.
module reg_bank #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int RESET_VALUE = 7,
  parameter bit SHADOWED    = 1'b1
) (
  input  logic      clock,
  input  logic      rst_n,
  reg_bank_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] active_q [DEPTH];
  logic [DEPTH-1:0] lock_q;

  // One-hot decodes; an address at or beyond DEPTH decodes to all zeros, which
  // makes it rejected for writes, ignored for locks and read back as zero.
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] lk_dec;
  logic [DEPTH-1:0] wr_sel;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_ok;
  logic             wr_rej;

  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             wr_err_q;
  logic             dirty_q;

  // Address decode, lock check and read mux
  always_comb begin
    wr_dec = '0;
    lk_dec = '0;
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_dec[i] = (bus.wr_addr == AW'(i));
      lk_dec[i] = (bus.lock_addr == AW'(i));
      if (bus.rd_addr == AW'(i)) rd_mux = active_q[i];
    end
    // The lock is sampled pre-edge, so a same-cycle lock does not block the write
    wr_ok  = bus.wr_en && (|(wr_dec & ~lock_q));
    wr_rej = bus.wr_en && !wr_ok;
    wr_sel = wr_ok ? wr_dec : '0;
  end

  generate
    if (SHADOWED) begin : g_shadow
      logic [WIDTH-1:0] shadow_q [DEPTH];

      // Staging copy: accepted writes land here first
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) shadow_q[i] <= RST_VAL;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) shadow_q[i] <= bus.wr_data;
          end
        end
      end

      // Commit publishes the post-write shadow image in one edge
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) active_q[i] <= RST_VAL;
        end else if (bus.commit) begin
          for (int i = 0; i < DEPTH; i++) begin
            active_q[i] <= wr_sel[i] ? bus.wr_data : shadow_q[i];
          end
        end
      end

      // Dirty tracks staged-but-unpublished writes; commit wins over a same-cycle write
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)          dirty_q <= 1'b0;
        else if (bus.commit) dirty_q <= 1'b0;
        else if (wr_ok)      dirty_q <= 1'b1;
      end
    end else begin : g_direct
      // Accepted writes go straight to the active registers; commit has no meaning
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) active_q[i] <= RST_VAL;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) active_q[i] <= bus.wr_data;
          end
        end
      end

      assign dirty_q = 1'b0;
    end
  endgenerate

  // Sticky lock bits, cleared only by reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)           lock_q <= '0;
    else if (bus.lock_en) lock_q <= lock_q | lk_dec;
  end

  // Registered read of the pre-edge active value; data holds when idle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_mux;
    end
  end

  // Rejected-write flag, one cycle after the offending request
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_rej;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.dirty    = dirty_q;
endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: two instances (DEPTH=4 shadowed, DEPTH=3 direct) share
// one stimulus stream; a reference model predicts every cycle's outputs into
// per-instance queues that a negedge monitor drains and compares.
module tb_reg_bank;
  localparam int W  = 8;
  localparam int AW = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  reg_bank_if #(.WIDTH(W), .AW(AW)) ifa ();
  reg_bank_if #(.WIDTH(W), .AW(AW)) ifb ();

  reg_bank #(.WIDTH(W), .DEPTH(4), .RESET_VALUE(7), .SHADOWED(1'b1))
    dut_a (.clock(clock), .rst_n(rst_n), .bus(ifa));
  reg_bank #(.WIDTH(W), .DEPTH(3), .RESET_VALUE(7), .SHADOWED(1'b0))
    dut_b (.clock(clock), .rst_n(rst_n), .bus(ifb));

  typedef struct packed {
    logic         rv;
    logic [W-1:0] rd;
    logic         err;
    logic         dirty;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: what software would believe the bank holds
  logic [W-1:0] m_act [2][4];
  logic [W-1:0] m_shd [2][4];
  bit           m_lck [2][4];
  bit           m_dirty [2];
  logic [W-1:0] m_hold [2];
  int           m_depth [2] = '{4, 3};
  bit           m_shad  [2] = '{1'b1, 1'b0};

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_act[d][i] = 8'd7;
        m_shd[d][i] = 8'd7;
        m_lck[d][i] = 1'b0;
      end
      m_dirty[d] = 1'b0;
      m_hold[d]  = 8'h00;
    end
  endfunction

  function automatic exp_t model_step(int d, bit we, int wa, int wd, bit le,
                                      int la, bit cm, bit re, int ra);
    exp_t e;
    bit   acc;
    e.rv = re;
    if (re) m_hold[d] = (ra < m_depth[d]) ? m_act[d][ra] : 8'h00;
    e.rd  = m_hold[d];
    acc   = we && (wa < m_depth[d]) && !m_lck[d][wa];
    e.err = we && !acc;
    if (m_shad[d]) begin
      if (acc) m_shd[d][wa] = wd[7:0];
      if (cm) begin
        for (int i = 0; i < 4; i++) m_act[d][i] = m_shd[d][i];
        m_dirty[d] = 1'b0;
      end else if (acc) begin
        m_dirty[d] = 1'b1;
      end
    end else if (acc) begin
      m_act[d][wa] = wd[7:0];
    end
    if (le && (la < m_depth[d])) m_lck[d][la] = 1'b1;
    e.dirty = m_dirty[d];
    return e;
  endfunction

  task automatic drive(input bit we, input int wa, input int wd, input bit le,
                       input int la, input bit cm, input bit re, input int ra);
    ifa.wr_en = we;  ifa.wr_addr = AW'(wa);  ifa.wr_data = W'(wd);
    ifa.lock_en = le; ifa.lock_addr = AW'(la); ifa.commit = cm;
    ifa.rd_en = re;  ifa.rd_addr = AW'(ra);
    ifb.wr_en = we;  ifb.wr_addr = AW'(wa);  ifb.wr_data = W'(wd);
    ifb.lock_en = le; ifb.lock_addr = AW'(la); ifb.commit = cm;
    ifb.rd_en = re;  ifb.rd_addr = AW'(ra);
  endtask

  // One clocked request: inputs change just after the monitor's negedge sample
  task automatic step(input bit we, input int wa, input int wd, input bit le,
                      input int la, input bit cm, input bit re, input int ra);
    @(negedge clock);
    #1;
    drive(we, wa, wd, le, la, cm, re, ra);
    q_a.push_back(model_step(0, we, wa, wd, le, la, cm, re, ra));
    q_b.push_back(model_step(1, we, wa, wd, le, la, cm, re, ra));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset right now, dropping anything still in flight
  task automatic reset_now();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst a.rd_data", ifa.rd_data, 0);
    check("rst a.rd_valid", ifa.rd_valid, 0);
    check("rst a.wr_err", ifa.wr_err, 0);
    check("rst a.dirty", ifa.dirty, 0);
    check("rst b.rd_data", ifb.rd_data, 0);
    check("rst b.rd_valid", ifb.rd_valid, 0);
    check("rst b.wr_err", ifb.wr_err, 0);
    check("rst b.dirty", ifb.dirty, 0);
    q_a.delete();
    q_b.delete();
    model_reset();
    @(negedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents an output, compare it to the prediction
  always @(negedge clock) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a.rd_valid", ifa.rd_valid, e.rv);
      check("a.rd_data", ifa.rd_data, e.rd);
      check("a.wr_err", ifa.wr_err, e.err);
      check("a.dirty", ifa.dirty, e.dirty);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b.rd_valid", ifb.rd_valid, e.rv);
      check("b.rd_data", ifb.rd_data, e.rd);
      check("b.wr_err", ifb.wr_err, e.err);
      check("b.dirty", ifb.dirty, e.dirty);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    reset_now();

    // Reset values on every address, including the out-of-range one for DEPTH=3
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, i);

    // Staged write is invisible until commit
    step(1, 2, 8'hA5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2);

    // Locked register rejects writes
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 8'h3C, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Same-cycle write and lock: write wins, lock applies afterwards
    step(1, 3, 8'h11, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(1, 3, 8'h22, 0, 0, 0, 0, 0);
    idle();

    // Out-of-range write and read
    step(1, 3, 8'h77, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 1, 3);

    // Write plus commit in one cycle alongside an earlier staged value
    step(1, 2, 8'h99, 0, 0, 0, 0, 0);
    step(1, 0, 8'h42, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Write/read same cycle (no bypass), then reset with a read in flight
    reset_now();
    step(1, 1, 8'h5A, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 2, 8'hEE, 0, 0, 0, 1, 2);
    reset_now();
    step(0, 0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Randomised traffic in a few reset epochs so locks do not saturate
    for (int epoch = 0; epoch < 3; epoch++) begin
      reset_now();
      for (int n = 0; n < 150; n++) begin
        step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
             ($urandom_range(0, 15) == 0), $urandom_range(0, 3),
             ($urandom_range(0, 5) == 0),
             $urandom_range(0, 1), $urandom_range(0, 3));
      end
    end

    idle();
    idle();
    @(negedge clock);
    @(negedge clock);
    #1;
    check("drain", q_a.size() + q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
